pe_array_seq: RTL and testbench

PE_ARRAY_SEQ -- requirements
Module: pe_array_seq

---
 rtl/pe_array_seq.sv | 147 ++++++++++++++
 tb/tb_pe_array_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_seq.sv
// Sequencer that buffers a frame of samples, issues them to a PE array lane,
// and forwards the array's results with completion and timeout reporting.
module pe_array_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int N           = 8,
  parameter int N_OUT       = 8,
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cfg_sel_inv,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] arr_x,
  output logic                  arr_sumDiffSel,
  output logic                  arr_load,
  input  logic [DATA_WIDTH-1:0] arr_z,
  input  logic                  arr_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(N_OUT) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [CW-1:0] N_M1    = CW'(N - 1);
  localparam logic [CW-1:0] LC_W    = CW'(LOAD_CYCLES);
  localparam logic [RW-1:0] NOUT    = RW'(N_OUT);
  localparam logic [RW-1:0] NOUT_M1 = RW'(N_OUT - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT - 1);

  logic [1:0]            state;
  logic                  sel_inv;
  logic [CW-1:0]         fill_cnt;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         nk;
  logic [RW-1:0]         res_cnt;
  logic [TW-1:0]         drain_cnt;
  logic [DATA_WIDTH-1:0] mem [N];

  logic active;
  logic finish;
  logic take;
  logic last;

  // done/err pulse while the FSM still sits in ISSUE/DRAIN; IDLE follows
  assign active  = (state == S_ISSUE) || (state == S_DRAIN);
  assign finish  = done || err;
  assign take    = active && !finish && arr_valid && (res_cnt < NOUT);
  assign last    = take && (res_cnt == NOUT_M1);
  assign nk      = issue_cnt + CW'(1);
  assign s_ready = (state == S_FILL);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (state == S_FILL && s_valid)
      mem[fill_cnt[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      sel_inv        <= 1'b0;
      fill_cnt       <= '0;
      issue_cnt      <= '0;
      res_cnt        <= '0;
      drain_cnt      <= '0;
      arr_x          <= '0;
      arr_sumDiffSel <= 1'b0;
      arr_load       <= 1'b0;
      m_data         <= '0;
      m_valid        <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done    <= last;
      m_valid <= take;
      err     <= 1'b0;
      if (take) begin
        m_data  <= arr_z;
        res_cnt <= res_cnt + RW'(1);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FILL;
            sel_inv   <= cfg_sel_inv;
            fill_cnt  <= '0;
            issue_cnt <= '0;
            res_cnt   <= '0;
            drain_cnt <= '0;
          end
        end
        S_FILL: begin
          if (s_valid) begin
            fill_cnt <= fill_cnt + CW'(1);
            if (fill_cnt == N_M1) begin
              state          <= S_ISSUE;
              issue_cnt      <= '0;
              arr_x          <= mem[0];
              arr_sumDiffSel <= sel_inv;
              arr_load       <= (LC_W != '0);
            end
          end
        end
        S_ISSUE: begin
          if (finish || issue_cnt == N_M1) begin
            state          <= finish ? S_IDLE : S_DRAIN;
            drain_cnt      <= '0;
            arr_x          <= '0;
            arr_sumDiffSel <= 1'b0;
            arr_load       <= 1'b0;
          end else begin
            issue_cnt      <= nk;
            arr_x          <= mem[nk[AW-1:0]];
            arr_sumDiffSel <= nk[0] ^ sel_inv;
            arr_load       <= (nk < LC_W);
          end
        end
        S_DRAIN: begin
          if (finish) begin
            state <= S_IDLE;
          end else begin
            drain_cnt <= drain_cnt + TW'(1);
            if (drain_cnt == TO_M1 && !last)
              err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_seq.sv
// Bench for pe_array_seq: frame issue pattern, result forwarding,
// timeout, mid-frame reset and ignored controls against a cycle-log model.
module tb_pe_array_seq;

  localparam int DW  = 8;
  localparam int N   = 8;
  localparam int NO  = 8;
  localparam int LC  = 2;
  localparam int TO  = 64;
  localparam int LOG = 4096;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic          cfg_sel_inv = 0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 0;
  logic          s_ready;
  logic [DW-1:0] arr_x;
  logic          arr_sumDiffSel;
  logic          arr_load;
  logic [DW-1:0] arr_z = '0;
  logic          arr_valid = 0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          busy;
  logic          done;
  logic          err;

  pe_array_seq #(
    .DATA_WIDTH(DW), .N(N), .N_OUT(NO),
    .LOAD_CYCLES(LC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_sel_inv(cfg_sel_inv), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready),
    .arr_x(arr_x), .arr_sumDiffSel(arr_sumDiffSel),
    .arr_load(arr_load), .arr_z(arr_z),
    .arr_valid(arr_valid), .m_data(m_data),
    .m_valid(m_valid), .busy(busy),
    .done(done), .err(err)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [DW-1:0] samp [N];
  int            vq [$];
  logic [DW-1:0] zq [$];

  logic [DW-1:0] x_log  [LOG];
  logic [DW-1:0] md_log [LOG];
  logic sel_log [LOG];
  logic ld_log  [LOG];
  logic mv_log  [LOG];
  logic dn_log  [LOG];
  logic er_log  [LOG];
  logic by_log  [LOG];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOG) begin
      x_log[cyc]  = arr_x;
      sel_log[cyc] = arr_sumDiffSel;
      ld_log[cyc] = arr_load;
      md_log[cyc] = m_data;
      mv_log[cyc] = m_valid;
      dn_log[cyc] = done;
      er_log[cyc] = err;
      by_log[cyc] = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_frame(input bit inv, input bit tog, input bit hold,
                            output int i0, output int fc);
    int  i;
    bit  acc;
    i  = 0;
    fc = 0;
    start = 1;
    cfg_sel_inv = inv;
    tick();
    start = hold;
    cfg_sel_inv = 0;
    while (i < N && fc < 4 * N) begin
      s_valid = tog ? (fc % 2 == 0) : 1'b1;
      s_data  = samp[i];
      acc = s_valid && s_ready;
      tick();
      if (acc) i++;
      fc++;
    end
    s_valid = 0;
    start = 0;
    i0 = cyc;
  endtask

  task automatic drive_results(input int first, input int cnt, input int base,
                               input int stop, input int st0, input int st1);
    vq.delete();
    zq.delete();
    while (cyc < stop) begin
      start = (cyc == st0) || (cyc == st1);
      if (cyc >= first && cyc < first + cnt) begin
        arr_valid = 1;
        arr_z = (base >= 0) ? DW'(base + cyc - first) : DW'($urandom);
        vq.push_back(cyc);
        zq.push_back(arr_z);
      end else begin
        arr_valid = 0;
      end
      tick();
    end
    arr_valid = 0;
    start = 0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({s_ready, arr_x, arr_sumDiffSel, arr_load, m_data,
         m_valid, busy, done, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%0b x=%0d mv=%0b want all 0",
               busy, arr_x, m_valid);
    end
    tick();
    tick();
    rst_n = 1;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%0b want 0", busy);
    end
  endtask

  task automatic test_issue(input bit inv, input bit tog, input bit seq);
    int i0, fc;
    bit ok;
    for (int i = 0; i < N; i++) samp[i] = seq ? DW'(i) : DW'($urandom);
    feed_frame(inv, tog, 0, i0, fc);
    tests++;
    if (fc !== (tog ? 2 * N - 1 : N)) begin
      fails++;
      $display("FAIL fill_cycles: got %0d want %0d", fc, tog ? 2 * N - 1 : N);
    end
    drive_results(i0 + 3, NO, 100, i0 + NO + 5, -1, -1);
    wait_idle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL issue_idle: busy stuck");
    end
    for (int k = 0; k < N; k++) begin
      tests++;
      if (x_log[i0+k] !== samp[k] ||
          sel_log[i0+k] !== ((k % 2 == 1) ^ inv) ||
          ld_log[i0+k] !== (k < LC)) begin
        fails++;
        $display("FAIL issue k=%0d: got x=%0d sel=%0b ld=%0b want x=%0d sel=%0b ld=%0b",
                 k, x_log[i0+k], sel_log[i0+k], ld_log[i0+k],
                 samp[k], (k % 2 == 1) ^ inv, k < LC);
      end
    end
    tests++;
    if ({x_log[i0+N], sel_log[i0+N], ld_log[i0+N],
         ld_log[i0-1]} !== '0) begin
      fails++;
      $display("FAIL issue_edges: got x=%0d sel=%0b ld=%0b pre_ld=%0b want 0",
               x_log[i0+N], sel_log[i0+N], ld_log[i0+N], ld_log[i0-1]);
    end
  endtask

  task automatic test_results();
    int i0, fc, d, stop;
    bit ok;
    for (int i = 0; i < N; i++) samp[i] = DW'($urandom);
    feed_frame(0, 0, 0, i0, fc);
    stop = i0 + NO + 6;
    drive_results(i0 + 3, NO, 100, stop, -1, -1);
    wait_idle(ok);
    d = i0 + 3 + NO;
    for (int c = i0; c < stop; c++) begin
      logic          emv;
      logic [DW-1:0] emd;
      emv = 0;
      emd = '0;
      if (c >= i0 + 4 && c <= d) begin
        emv = 1;
        emd = DW'(100 + c - i0 - 4);
      end
      tests++;
      if (mv_log[c] !== emv || (emv && md_log[c] !== emd) ||
          dn_log[c] !== (c == d) || er_log[c] !== 1'b0) begin
        fails++;
        $display("FAIL result cyc+%0d: got mv=%0b md=%0d dn=%0b er=%0b want mv=%0b md=%0d dn=%0b",
                 c - i0, mv_log[c], md_log[c], dn_log[c], er_log[c],
                 emv, emd, c == d);
      end
    end
    tests++;
    if (by_log[d] !== 1'b1 || by_log[d+1] !== 1'b0) begin
      fails++;
      $display("FAIL busy_fall: got %0b%0b want 10", by_log[d], by_log[d+1]);
    end
  endtask

  task automatic test_back_to_back();
    int i0, fc, nmv, stop;
    bit ok;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) samp[i] = DW'($urandom);
      feed_frame(f[0], 0, 0, i0, fc);
      stop = i0 + NO + 6;
      drive_results(i0, NO + 3, -1, stop, -1, -1);
      wait_idle(ok);
      nmv = 0;
      for (int c = i0; c < stop; c++) nmv += int'(mv_log[c]);
      tests++;
      if (nmv !== NO || mv_log[i0+1] !== 1'b1 || md_log[i0+1] !== zq[0] ||
          md_log[i0+NO] !== zq[NO-1] || dn_log[i0+NO] !== 1'b1) begin
        fails++;
        $display("FAIL b2b frame %0d: got nmv=%0d md0=%0d mdl=%0d dn=%0b want nmv=%0d md0=%0d mdl=%0d dn=1",
                 f, nmv, md_log[i0+1], md_log[i0+NO], dn_log[i0+NO],
                 NO, zq[0], zq[NO-1]);
      end
    end
  endtask

  task automatic test_timeout();
    int i0, fc, e, nerr, ndn, ferr, stop;
    bit ok;
    for (int i = 0; i < N; i++) samp[i] = DW'($urandom);
    feed_frame(0, 0, 0, i0, fc);
    e = i0 + N + TO;
    stop = e + 3;
    drive_results(i0 + 3, 5, -1, stop, -1, -1);
    wait_idle(ok);
    nerr = 0;
    ndn = 0;
    ferr = -1;
    for (int c = i0; c < stop; c++) begin
      nerr += int'(er_log[c]);
      ndn += int'(dn_log[c]);
      if (er_log[c] && ferr < 0) ferr = c;
    end
    tests++;
    if (ferr !== e || nerr !== 1) begin
      fails++;
      $display("FAIL timeout_err: got cyc+%0d count %0d want cyc+%0d count 1",
               ferr - i0, nerr, e - i0);
    end
    tests++;
    if (ndn !== 0) begin
      fails++;
      $display("FAIL timeout_done: got %0d pulses want 0", ndn);
    end
    tests++;
    if (by_log[e] !== 1'b1 || by_log[e+1] !== 1'b0 || md_log[e] !== zq[4]) begin
      fails++;
      $display("FAIL timeout_idle: got busy %0b%0b md=%0d want 10 md=%0d",
               by_log[e], by_log[e+1], md_log[e], zq[4]);
    end
  endtask

  task automatic test_reset_mid();
    int i0, fc, r0, bad;
    bit ok;
    for (int i = 0; i < N; i++) samp[i] = DW'($urandom);
    feed_frame(0, 0, 0, i0, fc);
    for (int k = 0; k < 4; k++) tick();
    tests++;
    if (arr_x !== samp[4]) begin
      fails++;
      $display("FAIL pre_reset_x: got %0d want %0d", arr_x, samp[4]);
    end
    rst_n = 0;
    #1;
    tests++;
    if ({s_ready, arr_x, arr_sumDiffSel, arr_load, m_data,
         m_valid, busy, done, err} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got busy=%0b x=%0d ld=%0b want all 0",
               busy, arr_x, arr_load);
    end
    r0 = cyc;
    tick();
    tick();
    rst_n = 1;
    tick();
    bad = 0;
    for (int c = i0; c < cyc; c++) bad += int'(dn_log[c]) + int'(er_log[c]);
    tests++;
    if (bad !== 0 || by_log[r0+1] !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_pulses: got %0d pulses busy=%0b want 0",
               bad, by_log[r0+1]);
    end
    test_issue(0, 0, 1);
  endtask

  task automatic test_ignored();
    int i0, fc, first, d, stop;
    bit ok;
    arr_valid = 1;
    arr_z = DW'($urandom);
    tick();
    arr_valid = 0;
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_valid: got mv=%0b busy=%0b want 0 0", m_valid, busy);
    end
    for (int i = 0; i < N; i++) samp[i] = DW'($urandom);
    feed_frame(0, 0, 1, i0, fc);
    first = i0 + N + 2;
    d = first + NO;
    stop = d + 4;
    drive_results(first, NO, -1, stop, i0 + N, d);
    wait_idle(ok);
    tests++;
    if (fc !== N || x_log[i0+3] !== samp[3] || by_log[i0+N+1] !== 1'b1) begin
      fails++;
      $display("FAIL start_in_fill: got fc=%0d x3=%0d busy=%0b want %0d %0d 1",
               fc, x_log[i0+3], by_log[i0+N+1], N, samp[3]);
    end
    tests++;
    if (dn_log[d] !== 1'b1 || dn_log[d-1] !== 1'b0 ||
        md_log[d] !== zq[NO-1] || mv_log[first] !== 1'b0) begin
      fails++;
      $display("FAIL ignored_done: got dn=%0b pre=%0b md=%0d want 1 0 %0d",
               dn_log[d], dn_log[d-1], md_log[d], zq[NO-1]);
    end
    tests++;
    if (by_log[d+1] !== 1'b0 || by_log[d+2] !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL start_on_done: got busy %0b%0b%0b want 000",
               by_log[d+1], by_log[d+2], busy);
    end
  endtask

  initial begin
    test_reset();
    test_issue(0, 0, 1);
    test_issue(1, 1, 0);
    test_results();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
